// File: rtl/stream_demux_pkg.sv
// Shared constants and encodings for the stream demultiplexer and its per-output buffers.
package stream_demux_pkg;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned CNT_W      = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    typedef enum logic {
        PTR_B = 1'b0,
        PTR_A = 1'b1
    } rr_e;

endpackage

// File: rtl/stream_demux_skid_fifo2.sv
// Two-entry registered buffer with push/pop handshake; entry 0 is always the head.
module skid_fifo2
    import stream_demux_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          full_o
);

    occ_e          state_q, state_d;
    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [DW-1:0] mem_d [FIFO_DEPTH];
    logic          push;
    logic          pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
        end
    end

    // Occupancy transitions; a push into ONE that also pops replaces the head.
    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        push    = push_i && (state_q != FULL);
        pop     = (state_q != EMPTY) && ready_i;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d  = ONE;
                    mem_d[0] = push_data_i;
                end
            end
            ONE: begin
                case ({push, pop})
                    2'b11: mem_d[0] = push_data_i;
                    2'b10: begin
                        state_d  = FULL;
                        mem_d[1] = push_data_i;
                    end
                    2'b01: state_d = EMPTY;
                    default: ;
                endcase
            end
            FULL: begin
                if (pop) begin
                    state_d  = ONE;
                    mem_d[0] = mem_q[1];
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign valid_o = (state_q != EMPTY);
    assign full_o  = (state_q == FULL);
    assign data_o  = mem_q[0];

endmodule

// File: rtl/stream_demux.sv
// 1:2 stream demultiplexer, directed (sel) or round-robin routing, one 2-entry buffer per output.
// Optional pop counters cnt_a/cnt_b are built when STREAM_DEMUX_CNT_EN is defined.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          sel,
    input  logic          mode,
    output logic [DW-1:0] out_a_data,
    output logic          out_a_valid,
    input  logic          out_a_ready,
    output logic [DW-1:0] out_b_data,
    output logic          out_b_valid,
    input  logic          out_b_ready,
    output logic          rr_ptr
`ifdef STREAM_DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
`endif
);

    rr_e  rr_q, rr_d;
    logic en_q;
    logic tgt_a;
    logic full_a, full_b;
    logic accept;

    // en_q holds in_ready low until the first edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= PTR_A;
            en_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
            en_q <= 1'b1;
        end
    end

    always_comb begin
        rr_d = rr_q;
        case (rr_q)
            PTR_A: if (accept && mode) rr_d = PTR_B;
            PTR_B: if (accept && mode) rr_d = PTR_A;
        endcase
    end

    assign tgt_a    = mode ? (rr_q == PTR_A) : sel;
    assign in_ready = en_q && !(tgt_a ? full_a : full_b);
    assign accept   = in_valid && in_ready;
    assign rr_ptr   = rr_q;

    skid_fifo2 #(.DW(DW)) u_fifo_a (
        .clk         (clk),
        .rst         (rst),
        .push_i      (accept && tgt_a),
        .push_data_i (in_data),
        .ready_i     (out_a_ready),
        .valid_o     (out_a_valid),
        .data_o      (out_a_data),
        .full_o      (full_a)
    );

    skid_fifo2 #(.DW(DW)) u_fifo_b (
        .clk         (clk),
        .rst         (rst),
        .push_i      (accept && !tgt_a),
        .push_data_i (in_data),
        .ready_i     (out_b_ready),
        .valid_o     (out_b_valid),
        .data_o      (out_b_data),
        .full_o      (full_b)
    );

`ifdef STREAM_DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_a_q, cnt_b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            if (out_a_valid && out_a_ready) cnt_a_q <= cnt_a_q + CNT_W'(1);
            if (out_b_valid && out_b_ready) cnt_b_q <= cnt_b_q + CNT_W'(1);
        end
    end

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: driver queues expected beats, negedge monitor checks pops.
module tb_stream_demux;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       sel;
    logic       mode;
    logic [7:0] out_a_data, out_b_data;
    logic       out_a_valid, out_b_valid;
    logic       out_a_ready, out_b_ready;
    logic       rr_ptr;
`ifdef STREAM_DEMUX_CNT_EN
    logic [7:0] cnt_a, cnt_b;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    bit          rr_m = 1'b1;

    stream_demux #(.DW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sel         (sel),
        .mode        (mode),
        .out_a_data  (out_a_data),
        .out_a_valid (out_a_valid),
        .out_a_ready (out_a_ready),
        .out_b_data  (out_b_data),
        .out_b_valid (out_b_valid),
        .out_b_ready (out_b_ready),
        .rr_ptr      (rr_ptr)
`ifdef STREAM_DEMUX_CNT_EN
        ,
        .cnt_a       (cnt_a),
        .cnt_b       (cnt_b)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every beat the DUT hands off must be the oldest expected beat for that port.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_a_valid && out_a_ready) begin
                if (qa.size() == 0) begin
                    total++; bad++;
                    $display("FAIL a_unexpected: got %0h expected none", out_a_data);
                end else chk("a_order", 32'(out_a_data), 32'(qa.pop_front()));
            end
            if (out_b_valid && out_b_ready) begin
                if (qb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL b_unexpected: got %0h expected none", out_b_data);
                end else chk("b_order", 32'(out_b_data), 32'(qb.pop_front()));
            end
        end
    end

    // Present one beat (leaves in_valid high so consecutive calls are back-to-back).
    task automatic send(input logic [7:0] d, input bit lat);
        bit acc  = 1'b0;
        bit to_a = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int w = 0; w < 40 && !acc; w++) begin
            @(negedge clk);
            if (in_ready) begin
                to_a = mode ? rr_m : sel;
                if (to_a) qa.push_back(d);
                else      qb.push_back(d);
                if (mode) rr_m = ~rr_m;
                acc = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!acc) begin
            total++; bad++;
            $display("FAIL accept_timeout: got no accept expected accept of %0h", d);
        end else if (lat) begin
            if (to_a) begin
                chk("lat_a_valid", 32'(out_a_valid), 32'd1);
                chk("lat_a_data", 32'(out_a_data), 32'(d));
            end else begin
                chk("lat_b_valid", 32'(out_b_valid), 32'd1);
                chk("lat_b_data", 32'(out_b_data), 32'(d));
            end
        end
    endtask

    task automatic drain();
        out_a_ready = 1'b1;
        out_b_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("drain_a_empty", 32'(qa.size()), 32'd0);
        chk("drain_b_empty", 32'(qb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        sel = 1'b1; mode = 1'b0; out_a_ready = 1'b0; out_b_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_valid", 32'(out_a_valid), 32'd0);
        chk("rst_b_valid", 32'(out_b_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_rr_ptr", 32'(rr_ptr), 32'd1);
        chk("rst_a_data", 32'(out_a_data), 32'd0);
        chk("rst_b_data", 32'(out_b_data), 32'd0);
        @(negedge clk) rst = 1'b0;
        #1 chk("ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("ready_after_release", 32'(in_ready), 32'd1);

        // Directed to A while A is stalled.
        send(8'h11, 1'b1);
        send(8'h22, 1'b0);
        in_valid = 1'b0;
        chk("a_full_ready", 32'(in_ready), 32'd0);
        chk("a_head_kept", 32'(out_a_data), 32'h11);
        chk("b_idle", 32'(out_b_valid), 32'd0);

        // B still accepts while A is full.
        sel = 1'b0;
        #1 chk("b_ready_while_a_full", 32'(in_ready), 32'd1);
        send(8'h33, 1'b1);
        in_valid = 1'b0;
        chk("a_still_full", 32'(out_a_valid), 32'd1);
        sel = 1'b1;
        #1 chk("sel_flip_ready", 32'(in_ready), 32'd0);
        drain();

        // Round-robin, back-to-back.
        mode = 1'b1;
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
        in_valid = 1'b0;
        chk("rr_end", 32'(rr_ptr), 32'd1);
        drain();

        // Push and pop on a ONE buffer.
        mode = 1'b0; sel = 1'b1; out_a_ready = 1'b0;
        send(8'h55, 1'b1);
        out_a_ready = 1'b1;
        send(8'hAA, 1'b1);
        out_a_ready = 1'b0;
        in_valid = 1'b0;
        #1 chk("one_stays_one", 32'(in_ready), 32'd1);
        chk("one_head", 32'(out_a_data), 32'hAA);
        drain();

        // Asynchronous reset with both buffers full.
        out_a_ready = 1'b0; out_b_ready = 1'b0;
        sel = 1'b1;
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        sel = 1'b0;
        send(8'hB1, 1'b0);
        send(8'hB2, 1'b0);
        in_valid = 1'b0;
        chk("b_full_ready", 32'(in_ready), 32'd0);
        mode = 1'b1;
        #2;
        rst = 1'b1;
        qa.delete(); qb.delete(); rr_m = 1'b1;
        #1;
        chk("async_a_valid", 32'(out_a_valid), 32'd0);
        chk("async_b_valid", 32'(out_b_valid), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        send(8'h77, 1'b1);
        in_valid = 1'b0;
        chk("post_rst_b_idle", 32'(out_b_valid), 32'd0);
        chk("post_rst_rr", 32'(rr_ptr), 32'd0);
        drain();

`ifdef STREAM_DEMUX_CNT_EN
        @(negedge clk) rst = 1'b1;
        qa.delete(); qb.delete(); rr_m = 1'b1;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        mode = 1'b0; sel = 1'b1; out_a_ready = 1'b1; out_b_ready = 1'b1;
        for (int i = 0; i < 257; i++) send(8'(i), 1'b0);
        in_valid = 1'b0;
        drain();
        chk("cnt_a_wrap", 32'(cnt_a), 32'd1);
        chk("cnt_b_hold", 32'(cnt_b), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter DW, default 8: data width in bits of every data port.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_data  input  DW  upstream data beat.
REQ-005 in_valid  input  1  upstream beat present.
REQ-006 in_ready  output  1  block accepts the beat this cycle.
REQ-007 sel  input  1  route select in directed mode: 1 = port A, 0 = port B (same polarity as the team's 2:1 mux).
REQ-008 mode  input  1  0 = directed by sel; 1 = round-robin.
REQ-009 out_a_data / out_b_data  output  DW  head entry of the A / B buffer.
REQ-010 out_a_valid / out_b_valid  output  1  A / B buffer non-empty.
REQ-011 out_a_ready / out_b_ready  input  1  downstream A / B accepts its head.
REQ-012 rr_ptr  output  1  round-robin target: 1 = A, 0 = B.

Function
REQ-013 A beat is accepted when in_valid and in_ready are both high on a rising clk edge.
REQ-014 Target: sel when mode=0, rr_ptr when mode=1, both sampled in the accept cycle.
REQ-015 in_ready shall be high iff the target buffer holds fewer than 2 entries; it is combinational from sel, mode, rr_ptr and buffer state only, never from in_valid.
REQ-016 Each output owns a 2-entry FIFO with states EMPTY, ONE, FULL; push only, pop only, and push+pop transitions follow the occupancy count.
REQ-017 Latency: an accepted beat appears on its out_x_data with out_x_valid high on the cycle after acceptance; there is no combinational bypass.
REQ-018 A pop occurs when out_x_valid and out_x_ready are both high; beat order per output equals acceptance order.
REQ-019 Push and pop on a ONE buffer in the same cycle leave it at ONE, with the new beat at the head next cycle.
REQ-020 A FULL buffer deasserts in_ready toward itself even if it pops in the same cycle; a pop from FULL goes to ONE.
REQ-021 A stalled output never blocks the other output: with A FULL and target B, in_ready stays high.
REQ-022 rr_ptr is a 2-state FSM (A, B); it toggles only on an accepted beat while mode=1, and holds otherwise.
REQ-023 A change of mode or sel takes effect in the same cycle for routing; buffered beats are unaffected.
REQ-024 out_x_data is don't-care while out_x_valid is low, but shall still be driven to a defined value.

Reset
REQ-025 While rst is high: both buffers EMPTY, out_a_valid=out_b_valid=0, in_ready=0, rr_ptr=1, out data 0, counters 0.
REQ-026 Reset asserted mid-transfer discards all buffered beats immediately and asynchronously; in_ready returns high on the first clk edge after rst falls.

Configuration
REQ-027 With macro STREAM_DEMUX_CNT_EN defined, outputs cnt_a and cnt_b (8 bits each) count beats popped on A / B, wrapping 255->0, reset to 0.
REQ-028 Without STREAM_DEMUX_CNT_EN, the cnt_a and cnt_b ports and their logic are absent; all other behaviour is identical.

Structure
REQ-029 Shared package stream_demux_pkg holds the buffer depth constant (2), the occupancy state encodings (EMPTY, ONE, FULL), the round-robin encodings (PTR_A=1, PTR_B=0) and the counter width (8).
REQ-030 The per-output buffer is sub-module skid_fifo2 (push/pop handshake, 2 entries), instantiated once for A and once for B.

Verification
REQ-031 Reset then mode=0, sel=1, send 8'h11 and 8'h22 with out_a_ready=0 -> out_a_valid=1 with out_a_data=8'h11 on the cycle after the first accept; after the second accept in_ready=0 with sel=1; out_b_valid stays 0.
REQ-032 Continue REQ-031 with sel=0 and send 8'h33 -> accepted while A stays FULL; out_b_data=8'h33 next cycle.
REQ-033 mode=1, out ready both 1, send 8'h01..8'h04 back-to-back -> A receives 01, 03 and B receives 02, 04, each one cycle after accept; rr_ptr ends at 1.
REQ-034 A at ONE, push 8'hAA to A and pop in the same cycle -> A stays ONE with head 8'hAA next cycle.
REQ-035 Assert rst asynchronously mid-cycle with both buffers FULL -> both valids drop before the next edge; after release the first beat is routed to A in round-robin.
REQ-036 With STREAM_DEMUX_CNT_EN, pop 257 beats on A -> cnt_a=1, cnt_b unchanged.
